eth_rx_pad36: RTL and testbench



---
 rtl/fifo36_pkg.sv | 40 ++++
 rtl/rollback_buf36.sv | 68 ++++++
 rtl/eth_rx_pad36.sv | 123 ++++++++++++
 tb/tb_eth_rx_pad36.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo36_pkg.sv
// Shared field layout of the 36-bit framed stream and receive-framer types.
package fifo36_pkg;

  localparam int unsigned FIFO36_SOF_BIT = 32;
  localparam int unsigned FIFO36_EOF_BIT = 33;
  localparam int unsigned FIFO36_OCC_LSB = 34;

  // Valid-byte count on the EOF word; 0 stands for a full word.
  localparam logic [1:0] OCC_4 = 2'd0;
  localparam logic [1:0] OCC_1 = 2'd1;
  localparam logic [1:0] OCC_2 = 2'd2;
  localparam logic [1:0] OCC_3 = 2'd3;

  localparam int unsigned ETH_PAD_BYTES = 2;

  typedef enum logic [1:0] {StIdle, StFill, StDrop} rx_state_e;

  function automatic logic [1:0] occ_encode(input logic [1:0] last_lane);
    logic [1:0] occ;
    unique case (last_lane)
      2'd0:    occ = OCC_1;
      2'd1:    occ = OCC_2;
      2'd2:    occ = OCC_3;
      default: occ = OCC_4;
    endcase
    return occ;
  endfunction

  function automatic logic [35:0] fifo36_word(input logic [31:0] data, input logic sof,
                                              input logic eof, input logic [1:0] occ);
    logic [35:0] w;
    w = '0;
    w[31:0] = data;
    w[FIFO36_SOF_BIT] = sof;
    w[FIFO36_EOF_BIT] = eof;
    w[FIFO36_OCC_LSB +: 2] = occ;
    return w;
  endfunction

endpackage

// File: rtl/rollback_buf36.sv
// Frame buffer with speculative write pointer, commit/rollback and a prefetching
// 36-bit output stage that only ever exposes committed words.
module rollback_buf36 #(
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [35:0]       wr_data,
  input  logic              commit,
  input  logic              rollback,
  output logic              full,
  output logic [35:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH:0]   fill_words
);

  localparam int unsigned Depth = 2 ** AWIDTH;
  localparam int unsigned Fw = AWIDTH + 1;

  logic [35:0]       mem [Depth];
  logic [AWIDTH-1:0] wp_q, cp_q, rp_q, wr_addr, wp_next;
  logic [35:0]       ram_q, out_q;
  logic              ram_vld_q, out_vld_q;
  logic              rd_en, move, pop;

  always_comb begin
    // A rollback and a write in the same cycle restart the frame at the commit point.
    wr_addr    = rollback ? cp_q : wp_q;
    wp_next    = wr_en ? wr_addr + AWIDTH'(1) : wr_addr;
    full       = (wp_q + AWIDTH'(1)) == rp_q;
    pop        = out_vld_q & out_ready;
    move       = ram_vld_q & (~out_vld_q | pop);
    rd_en      = (rp_q != cp_q) & (~ram_vld_q | move);
    fill_words = {1'b0, wp_q - rp_q} + Fw'(ram_vld_q) + Fw'(out_vld_q);
    out_data   = out_q;
    out_valid  = out_vld_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[rp_q];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp_q      <= '0;
      cp_q      <= '0;
      rp_q      <= '0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wp_q <= wp_next;
      if (commit) cp_q <= wp_next;
      if (rd_en) rp_q <= rp_q + AWIDTH'(1);
      ram_vld_q <= rd_en | (ram_vld_q & ~move);
      if (move) out_q <= ram_q;
      out_vld_q <= move | (out_vld_q & ~pop);
    end
  end

endmodule

// File: rtl/eth_rx_pad36.sv
// MAC byte stream to padded, big-endian 36-bit frames; bad or truncated frames
// are rolled back so only complete good frames reach the dispatcher.
module eth_rx_pad36
  import fifo36_pkg::*;
#(
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic              rx_error,
  output logic [35:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       drop_count,
  output logic [AWIDTH:0]   fill_words
);

  rx_state_e   state_q, state_d;
  logic [1:0]  lane_q, lane_d, lane_eff;
  logic [31:0] acc_q, acc_d, merged;
  logic        first_q, first_d;
  logic [15:0] drop_q, drop_d;
  logic        start, drop_old, active, wr_need, bad_eof, overflow;
  logic        wr_en, commit, rollback, full;
  logic [35:0] wr_data;

  always_comb begin
    start    = rx_valid & rx_sof;
    drop_old = start & (state_q == StFill);
    active   = start | (rx_valid & (state_q == StFill));
    lane_eff = start ? 2'(ETH_PAD_BYTES) : lane_q;
    merged   = start ? '0 : acc_q;
    unique case (lane_eff)
      2'd0:    merged[31:24] = rx_data;
      2'd1:    merged[23:16] = rx_data;
      2'd2:    merged[15:8]  = rx_data;
      default: merged[7:0]   = rx_data;
    endcase
    wr_need  = active & ((lane_eff == 2'd3) | rx_eof);
    bad_eof  = active & rx_eof & rx_error;
    overflow = wr_need & full & ~bad_eof;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = rx_eof ? StIdle : StFill;
    end else if (rx_valid) begin
      case (state_q)
        StFill: begin
          if (rx_eof)        state_d = StIdle;
          else if (overflow) state_d = StDrop;
        end
        StDrop:  if (rx_eof) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en    = wr_need & ~full & ~bad_eof;
    commit   = active & rx_eof & ~rx_error & ~full;
    rollback = drop_old | bad_eof | overflow;
    wr_data  = fifo36_word(merged, start | first_q, rx_eof,
                           rx_eof ? occ_encode(lane_eff) : OCC_4);
    lane_d   = lane_q;
    acc_d    = acc_q;
    first_d  = first_q;
    if (active) begin
      lane_d  = lane_eff + 2'd1;
      acc_d   = wr_need ? '0 : merged;
      first_d = (start | first_q) & ~wr_need;
    end
    drop_d = drop_q + 16'(drop_old) + 16'(bad_eof | overflow);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_q  <= '0;
      acc_q   <= '0;
      first_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       drop_q <= '0;
    else if (!clr) drop_q <= drop_d;
  end

  assign drop_count = drop_q;

  rollback_buf36 #(
    .AWIDTH(AWIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .commit     (commit),
    .rollback   (rollback),
    .full       (full),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_words (fill_words)
  );

endmodule

// File: tb/tb_eth_rx_pad36.sv
// Randomized and directed bench for eth_rx_pad36 against a frame-level byte model.
module tb_eth_rx_pad36;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst6 = 1'b1, clr = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_error = 1'b0;
  logic [35:0] out_data, out_data6;
  logic        out_valid, out_valid6;
  logic        ready9 = 1'b1, ready6 = 1'b0, fixed_ready9 = 1'b1, rand_ready = 1'b0;
  logic [15:0] drop_count, drop_count6;
  logic [9:0]  fill_words;
  logic [6:0]  fill_words6;

  int n_checks = 0, n_pass = 0, m_drops = 0;
  logic [35:0] exp9[$], exp6[$], got9[$], got6[$];
  logic [7:0]  cur[$];
  bit          in_frame = 0, log6 = 0, stall = 0;
  logic [35:0] stall_data;

  eth_rx_pad36 #(.AWIDTH(9)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_error(rx_error), .out_data(out_data),
    .out_valid(out_valid), .out_ready(ready9), .drop_count(drop_count),
    .fill_words(fill_words)
  );

  eth_rx_pad36 #(.AWIDTH(6)) dut6 (
    .clk(clk), .rst(rst6), .clr(clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_error(rx_error), .out_data(out_data6),
    .out_valid(out_valid6), .out_ready(ready6), .drop_count(drop_count6),
    .fill_words(fill_words6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Padded frame -> words, straight from the byte-to-lane rule.
  task automatic model_emit();
    int n, nw, idx;
    logic [35:0] word;
    logic [7:0]  b;
    n  = cur.size() + 2;
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int l = 0; l < 4; l++) begin
        idx = 4 * w + l;
        b = 8'h00;
        if (idx >= 2 && idx < n) b = cur[idx - 2];
        word[31 - 8 * l -: 8] = b;
      end
      word[32] = (w == 0);
      word[33] = (w == nw - 1);
      if (w == nw - 1) word[35:34] = 2'(n % 4);
      exp9.push_back(word);
      if (log6) exp6.push_back(word);
    end
  endtask

  task automatic model_step(input logic [7:0] b, input logic s, input logic e,
                            input logic er, input logic v);
    if (!v) return;
    if (s) begin
      if (in_frame) m_drops++;
      cur.delete();
      in_frame = 1;
    end else if (!in_frame) begin
      return;
    end
    cur.push_back(b);
    if (e) begin
      in_frame = 0;
      if (er) m_drops++;
      else    model_emit();
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic s, input logic e,
                       input logic er, input logic v);
    rx_data = b; rx_sof = s; rx_eof = e; rx_error = er; rx_valid = v;
    model_step(b, s, e, er, v);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input int len, input int seed, input bit err);
    for (int i = 0; i < len; i++)
      drive(8'(seed + i), i == 0, i == len - 1, err && (i == len - 1), 1'b1);
  endtask

  task automatic send_partial(input int len, input int seed);
    for (int i = 0; i < len; i++) drive(8'(seed + i), i == 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    repeat (4) @(negedge clk);
    while ((exp9.size() != 0 || out_valid) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("drain_done", k < limit, 1);
  endtask

  always @(posedge clk) begin
    #1;
    ready9 = rand_ready ? ($urandom_range(3) != 0) : fixed_ready9;
  end

  // Word scoreboard and hold-while-stalled check for the AWIDTH=9 instance.
  always @(negedge clk) begin
    if (rst || clr) begin
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, stall_data);
      end
      stall = out_valid && !ready9;
      stall_data = out_data;
      if (out_valid && ready9) begin
        got9.push_back(out_data);
        if (exp9.size() == 0) check("unexpected_word", out_data, 36'h0);
        else check("word", out_data, exp9.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst6 && out_valid6 && ready6) got6.push_back(out_data6);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] lw;
    logic [3:0]  flags_tbl [4];
    int k, sofs, dsave;
    flags_tbl[0] = 4'hE; flags_tbl[1] = 4'h2; flags_tbl[2] = 4'h6; flags_tbl[3] = 4'hA;

    repeat (4) @(posedge clk);
    #1; rst = 1'b0; rst6 = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_fill", fill_words, 0);
    check("reset_drop", drop_count, 0);

    // 60-byte frame, counting pattern.
    got9.delete();
    send_frame(60, 0, 0);
    check("no_valid_before_commit", out_valid, 0);
    k = 0;
    while (!out_valid && k < 5) begin
      @(posedge clk); #1;
      k++;
    end
    check("commit_latency_le3", k <= 3, 1);
    drain(200);
    check("f60_words", got9.size(), 16);
    check("f60_word0", got9[0], 36'h1_0000_0001);
    check("f60_word1", got9[1], 36'h0_0203_0405);
    check("f60_last", got9[15], 36'hA_3A3B_0000);
    check("f60_drop", drop_count, 0);

    for (int i = 0; i < 4; i++) begin
      got9.delete();
      send_frame(61 + i, 7 * i, 0);
      drain(200);
      lw = got9[$];
      check("len_last_flags", lw[35:32], flags_tbl[i]);
    end

    // Errored frame is dropped whole.
    got9.delete();
    send_frame(100, 5, 1);
    repeat (6) @(negedge clk);
    check("err_drop_count", drop_count, 1);
    check("err_model_drops", drop_count, m_drops);
    check("err_no_words", got9.size(), 0);
    check("err_fill", fill_words, 0);

    // Overflow on the small instance with the output held off.
    rst6 = 1'b1;
    @(posedge clk); #1;
    rst6 = 1'b0;
    exp6.delete(); got6.delete(); log6 = 1;
    for (int f = 0; f < 3; f++) send_frame(100, 16 * f, 0);
    log6 = 0;
    repeat (6) @(posedge clk); #1;
    check("ovf_drop", drop_count6, 1);
    check("ovf_fill", fill_words6, 52);
    check("ovf_valid", out_valid6, 1);
    ready6 = 1'b1;
    k = 0;
    while (fill_words6 != 0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("ovf_drain_done", k < 500, 1);
    repeat (4) @(posedge clk); #1;
    check("ovf_words", got6.size(), 52);
    sofs = 0;
    for (int i = 0; i < got6.size(); i++) begin
      if (got6[i][32]) sofs++;
      if (i < exp6.size()) check("ovf_word", got6[i], exp6[i]);
    end
    check("ovf_sof_count", sofs, 2);
    check("ovf_sof0", got6[0][32], 1);
    check("ovf_sof26", got6[26][32], 1);
    drain(200);

    // Missing EOF: new SOF aborts frame A.
    got9.delete();
    dsave = drop_count;
    send_partial(20, 40);
    send_frame(64, 90, 0);
    drain(200);
    check("trunc_drop", drop_count, dsave + 1);
    check("trunc_words", got9.size(), 17);

    // clr mid-frame with 10 words committed and 2 speculative.
    fixed_ready9 = 1'b0;
    @(posedge clk); #1;
    send_frame(38, 3, 0);
    send_partial(9, 50);
    repeat (4) @(posedge clk); #1;
    check("clr_pre_fill", fill_words, 12);
    check("clr_pre_valid", out_valid, 1);
    dsave = drop_count;
    clr = 1'b1;
    exp9.delete(); cur.delete(); in_frame = 0;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_fill", fill_words, 0);
    check("clr_drop", drop_count, dsave);
    for (int i = 0; i < 5; i++) drive(8'(60 + i), 1'b0, i == 4, 1'b0, 1'b1);
    fixed_ready9 = 1'b1;
    got9.delete();
    send_frame(50, 11, 0);
    drain(200);
    check("clr_next_words", got9.size(), 13);
    check("clr_next_drop", drop_count, dsave);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len, seed;
      bit err, trunc, last;
      len = $urandom_range(90, 1); seed = $urandom_range(255);
      err = ($urandom_range(7) == 0); trunc = ($urandom_range(9) == 0);
      repeat ($urandom_range(2)) drive(8'($urandom_range(255)), 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1);
        if (trunc && last) break;
        drive(8'(seed + i), i == 0, last, last ? err : 1'($urandom_range(1)), 1'b1);
        if ($urandom_range(4) == 0) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      repeat ($urandom_range(3)) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_frame(33, 1, 0);
    drain(2000);
    check("rand_drop", drop_count, m_drops);
    check("rand_exp_empty", exp9.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
